// File: rtl/spike_train_decoder_if.sv
// Record stream from the spike train decoder to a host-side reader.
// The master drives the head record and its valid flag, and the slave
// returns ready.
interface spike_train_decoder_if #(
   parameter int DATA_WIDTH = 16,
   parameter int CNT_WIDTH  = 8,
   parameter int ISI_WIDTH  = 12
);
   logic                  out_valid;
   logic                  out_ready;
   logic [CNT_WIDTH-1:0]  out_count;
   logic [ISI_WIDTH-1:0]  out_isi_min;
   logic [DATA_WIDTH-1:0] out_v_peak;

   modport master (
      output out_valid,
      output out_count,
      output out_isi_min,
      output out_v_peak,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_count,
      input  out_isi_min,
      input  out_v_peak,
      output out_ready
   );
endinterface

// File: rtl/spike_train_decoder.sv
// Spike train decoder.
// Watches a neuron's spike flag and membrane value on every enabled cycle.
// Each fixed-length window is reduced to one summary record: spike count,
// minimum inter-spike interval and peak membrane. Records are queued in a
// shift-register FIFO whose slot 0 is the visible head, so every record
// output comes straight from a register.
module spike_train_decoder #(
   parameter int DATA_WIDTH    = 16,
   parameter int WINDOW_CYCLES = 256,
   parameter int CNT_WIDTH     = 8,
   parameter int ISI_WIDTH     = 12,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   enable,
   input  logic                   spike_in,
   input  logic [DATA_WIDTH-1:0]  v_mem_in,
   spike_train_decoder_if.master  rec_if,
   output logic [7:0]             drop_count,
   output logic                   overflow
);

   localparam int WIN_W = (WINDOW_CYCLES > 2) ? $clog2(WINDOW_CYCLES) : 1;
   localparam logic [WIN_W-1:0]     WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
   localparam logic [ISI_WIDTH-1:0] ISI_MAX  = {ISI_WIDTH{1'b1}};
   localparam logic [7:0]           DROP_MAX = 8'hFF;

   typedef struct packed {
      logic [CNT_WIDTH-1:0]  count;
      logic [ISI_WIDTH-1:0]  isi_min;
      logic [DATA_WIDTH-1:0] v_peak;
   } rec_t;

   // Window and interval tracking state.
   logic [WIN_W-1:0]      win_cnt_q,   win_cnt_d;
   logic                  prev_q,      prev_d;
   logic                  have_last_q, have_last_d;
   logic [ISI_WIDTH-1:0]  isi_cnt_q,   isi_cnt_d;
   logic [CNT_WIDTH-1:0]  acc_count_q, acc_count_d;
   logic [ISI_WIDTH-1:0]  acc_isi_q,   acc_isi_d;
   logic [DATA_WIDTH-1:0] acc_peak_q,  acc_peak_d;

   // Record FIFO state. Valid bits are always a thermometer from slot 0.
   rec_t                  ent_q [FIFO_DEPTH];
   rec_t                  ent_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] vld_q, vld_d;
   logic [7:0]            drop_q, drop_d;
   logic                  ovf_q,  ovf_d;

   // Per-cycle decode.
   logic                  event_s;
   logic                  first_s;
   logic                  last_s;
   logic                  push_s;
   logic                  pop_s;
   logic                  full_s;
   logic                  written_s;
   logic [CNT_WIDTH-1:0]  cur_count_s;
   logic [ISI_WIDTH-1:0]  cur_isi_s;
   logic [DATA_WIDTH-1:0] cur_peak_s;
   rec_t                  cur_rec_s;

   assign event_s = enable & spike_in & ~prev_q;
   assign first_s = (win_cnt_q == {WIN_W{1'b0}});
   assign last_s  = (win_cnt_q == WIN_LAST);
   assign push_s  = enable & last_s;
   assign pop_s   = vld_q[0] & rec_if.out_ready;
   assign full_s  = vld_q[FIFO_DEPTH-1];

   // Fold this cycle's event and sample into the running window summary.
   // The first cycle of a window starts fresh instead of merging.
   always_comb begin
      cur_count_s = first_s ? {CNT_WIDTH{1'b0}} : acc_count_q;
      cur_isi_s   = first_s ? ISI_MAX : acc_isi_q;
      cur_peak_s  = first_s ? v_mem_in : acc_peak_q;
      if (event_s && (cur_count_s != CNT_MAX)) begin
         cur_count_s = cur_count_s + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end else begin
         cur_count_s = cur_count_s;
      end
      if (event_s && have_last_q && (isi_cnt_q < cur_isi_s)) begin
         cur_isi_s = isi_cnt_q;
      end else begin
         cur_isi_s = cur_isi_s;
      end
      if (v_mem_in > cur_peak_s) begin
         cur_peak_s = v_mem_in;
      end else begin
         cur_peak_s = cur_peak_s;
      end
      cur_rec_s.count   = cur_count_s;
      cur_rec_s.isi_min = cur_isi_s;
      cur_rec_s.v_peak  = cur_peak_s;
   end

   // Advance window position, edge detector and interval counter; all
   // of it freezes while enable is low.
   always_comb begin
      win_cnt_d   = win_cnt_q;
      prev_d      = prev_q;
      have_last_d = have_last_q;
      isi_cnt_d   = isi_cnt_q;
      acc_count_d = acc_count_q;
      acc_isi_d   = acc_isi_q;
      acc_peak_d  = acc_peak_q;
      if (enable) begin
         prev_d      = spike_in;
         win_cnt_d   = last_s ? {WIN_W{1'b0}} : (win_cnt_q + {{(WIN_W-1){1'b0}}, 1'b1});
         acc_count_d = cur_count_s;
         acc_isi_d   = cur_isi_s;
         acc_peak_d  = cur_peak_s;
         if (event_s) begin
            // Distance to the next enabled cycle is one.
            have_last_d = 1'b1;
            isi_cnt_d   = {{(ISI_WIDTH-1){1'b0}}, 1'b1};
         end else if (have_last_q && (isi_cnt_q != ISI_MAX)) begin
            isi_cnt_d = isi_cnt_q + {{(ISI_WIDTH-1){1'b0}}, 1'b1};
         end else begin
            isi_cnt_d = isi_cnt_q;
         end
      end else begin
         win_cnt_d = win_cnt_q;
      end
   end

   // Shift FIFO: a pop moves everything toward the head, then a push
   // fills the first free slot. A push into a full FIFO with no pop is lost.
   always_comb begin
      ent_d     = ent_q;
      vld_d     = vld_q;
      drop_d    = drop_q;
      ovf_d     = ovf_q;
      written_s = 1'b0;
      if (pop_s) begin
         for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
            ent_d[i] = ent_q[i+1];
            vld_d[i] = vld_q[i+1];
         end
         ent_d[FIFO_DEPTH-1] = '0;
         vld_d[FIFO_DEPTH-1] = 1'b0;
      end else begin
         vld_d = vld_q;
      end
      if (push_s) begin
         if (full_s && !pop_s) begin
            ovf_d  = 1'b1;
            drop_d = (drop_q != DROP_MAX) ? (drop_q + 8'd1) : drop_q;
         end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
               if (!vld_d[i] && !written_s) begin
                  ent_d[i]  = cur_rec_s;
                  vld_d[i]  = 1'b1;
                  written_s = 1'b1;
               end else begin
                  written_s = written_s;
               end
            end
         end
      end else begin
         drop_d = drop_q;
      end
   end

   // Window/interval state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt_q   <= {WIN_W{1'b0}};
         prev_q      <= 1'b0;
         have_last_q <= 1'b0;
         isi_cnt_q   <= {ISI_WIDTH{1'b0}};
         acc_count_q <= {CNT_WIDTH{1'b0}};
         acc_isi_q   <= {ISI_WIDTH{1'b0}};
         acc_peak_q  <= {DATA_WIDTH{1'b0}};
      end else begin
         win_cnt_q   <= win_cnt_d;
         prev_q      <= prev_d;
         have_last_q <= have_last_d;
         isi_cnt_q   <= isi_cnt_d;
         acc_count_q <= acc_count_d;
         acc_isi_q   <= acc_isi_d;
         acc_peak_q  <= acc_peak_d;
      end
   end

   // FIFO storage and drop bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            ent_q[i] <= '0;
         end
         vld_q  <= {FIFO_DEPTH{1'b0}};
         drop_q <= 8'd0;
         ovf_q  <= 1'b0;
      end else begin
         ent_q  <= ent_d;
         vld_q  <= vld_d;
         drop_q <= drop_d;
         ovf_q  <= ovf_d;
      end
   end

   assign rec_if.out_valid   = vld_q[0];
   assign rec_if.out_count   = ent_q[0].count;
   assign rec_if.out_isi_min = ent_q[0].isi_min;
   assign rec_if.out_v_peak  = ent_q[0].v_peak;
   assign drop_count         = drop_q;
   assign overflow           = ovf_q;

endmodule
